// File: rtl/lampFPU_pkg.sv
// lampFPU_pkg: shared constants, FIFO entry type and the round-to-nearest-even
// helper for the bfloat16 square-root pack stage.
// The optional LAMP_SQRT_PACK_FLAGS_EN macro adds NX/OF/NV bits to each entry.
package lampFPU_pkg;

  localparam int LAMP_FLOAT_DW   = 16;
  localparam int LAMP_FLOAT_E_DW = 8;
  localparam int LAMP_FLOAT_F_DW = 7;

  // {exponent, fraction} encodings of the special values
  localparam logic [LAMP_FLOAT_E_DW+LAMP_FLOAT_F_DW-1:0] INF_E_F  = 15'b11111111_0000000;
  localparam logic [LAMP_FLOAT_E_DW+LAMP_FLOAT_F_DW-1:0] QNAN_E_F = 15'b11111111_1000000;

  // One buffered result; the packed word occupies the top 16 bits
  typedef struct packed {
    logic                       s;
    logic [LAMP_FLOAT_E_DW-1:0] e;
    logic [LAMP_FLOAT_F_DW-1:0] f;
`ifdef LAMP_SQRT_PACK_FLAGS_EN
    logic                       nx;
    logic                       of;
    logic                       nv;
`endif
  } lampSqrtPackEntry_t;

  // Rounded {e, frac} only. The carry bit f[11] arrives as 0, so using it as
  // the top bit of the 9-bit sum is the same as a zero pad.
  function automatic logic [14:0] FUNC_rndSqrtEF(input logic [7:0] e_i,
                                                  input logic [11:0] f_i);
    logic       up;
    logic [8:0] m;
    logic [7:0] e_o;
    logic [6:0] frac_o;
    up = f_i[2] & (f_i[1] | f_i[0] | f_i[3]);
    m  = {f_i[11], f_i[10:3]} + {8'd0, up};
    if (m[8]) begin
      frac_o = m[7:1];
      e_o    = e_i + 8'd1;
    end else begin
      frac_o = m[6:0];
      e_o    = e_i;
    end
    if (e_o == 8'hFF) begin
      return INF_E_F;
    end
    return {e_o, frac_o};
  endfunction

  // Full rounding result: {e[7:0], frac[6:0], NX, OF}
  function automatic logic [16:0] FUNC_rndNearestEvenSqrt(input logic [7:0] e_i,
                                                           input logic [11:0] f_i);
    logic [14:0] ef;
    logic        nx;
    logic        of;
    ef = FUNC_rndSqrtEF(e_i, f_i);
    nx = |f_i[2:0];
    of = (ef[14:7] == 8'hFF);
    return {ef, nx, of};
  endfunction

endpackage

// File: rtl/lamp_fpu_sqrt_res_fifo.sv
// lamp_fpu_sqrt_res_fifo: synchronous FIFO with async reset, wrap-bit
// full/empty detection and a registered free-entry count. The head is read
// straight from the storage registers and reads as zero while empty.
module lamp_fpu_sqrt_res_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     free_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q, free_q;
  logic [AW:0]      free_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_wr, do_rd;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_rd   = rd_en_i & ~empty_o;
  assign do_wr   = wr_en_i & (~full_o | do_rd);
  assign free_d  = free_q + {{AW{1'b0}}, do_rd} - {{AW{1'b0}}, do_wr};

  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign free_o    = free_q;

  // Pointer and free-count bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      free_q   <= (AW+1)'(DEPTH);
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      free_q <= free_d;
    end
  end

  // Storage write; contents are qualified by the pointers so need no reset
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/lamp_fpu_sqrt_pack.sv
// lamp_fpu_sqrt_pack: captures the unpacked square-root result, rounds to
// nearest-even (or passes specials through), packs bfloat16 and buffers the
// words in a small FIFO drained by valid/ready.
// Define LAMP_SQRT_PACK_FLAGS_EN to carry NX/OF/NV alongside each result.
module lamp_fpu_sqrt_pack
  import lampFPU_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int AF_FREE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        s_res_i,
  input  logic [7:0]  e_res_i,
  input  logic [11:0] f_res_i,
  input  logic        isToRound_i,
  output logic [15:0] result_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        almost_full_o,
  output logic        ovfl_o
`ifdef LAMP_SQRT_PACK_FLAGS_EN
  ,
  output logic        flagNX_o,
  output logic        flagOF_o,
  output logic        flagNV_o
`endif
);

  localparam int          AW        = $clog2(DEPTH);
  localparam int          EW        = $bits(lampSqrtPackEntry_t);
  localparam logic [AW:0] AF_FREE_W = (AW+1)'(AF_FREE);

  logic               s1_valid_q, s1_s_q, s1_rnd_q;
  logic [7:0]         s1_e_q;
  logic [11:0]        s1_f_q;
  lampSqrtPackEntry_t entry_d, head;
  logic [EW-1:0]      head_w;
  logic               fifo_full, fifo_empty;
  logic [AW:0]        fifo_free, free_after;
  logic               push, pop;
  logic               ovfl_q, ovfl_d, af_q, af_d;

  // Stage 1: capture the incoming result; data only loads on a valid cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_s_q     <= 1'b0;
      s1_rnd_q   <= 1'b0;
      s1_e_q     <= '0;
      s1_f_q     <= '0;
    end else begin
      s1_valid_q <= valid_i;
      if (valid_i) begin
        s1_s_q   <= s_res_i;
        s1_rnd_q <= isToRound_i;
        s1_e_q   <= e_res_i;
        s1_f_q   <= f_res_i;
      end
    end
  end

`ifdef LAMP_SQRT_PACK_FLAGS_EN
  logic [16:0] rnd_full;
  assign rnd_full = FUNC_rndNearestEvenSqrt(s1_e_q, s1_f_q);

  // Stage 2: round or pass through, with exception flags
  always_comb begin
    entry_d   = '0;
    entry_d.s = s1_s_q;
    if (s1_rnd_q) begin
      {entry_d.e, entry_d.f, entry_d.nx, entry_d.of} = rnd_full;
    end else begin
      entry_d.e  = s1_e_q;
      entry_d.f  = s1_f_q[9:3];
      entry_d.nv = (s1_e_q == 8'hFF) && (s1_f_q[9:3] != 7'd0);
    end
  end
`else
  logic [14:0] rnd_ef;
  assign rnd_ef = FUNC_rndSqrtEF(s1_e_q, s1_f_q);

  // Stage 2: round or pass through
  always_comb begin
    entry_d   = '0;
    entry_d.s = s1_s_q;
    if (s1_rnd_q) begin
      {entry_d.e, entry_d.f} = rnd_ef;
    end else begin
      entry_d.e = s1_e_q;
      entry_d.f = s1_f_q[9:3];
    end
  end
`endif

  // A full FIFO still accepts a write when the head leaves in the same cycle
  assign pop        = ready_i & ~fifo_empty;
  assign push       = s1_valid_q & (~fifo_full | pop);
  assign free_after = fifo_free - {{AW{1'b0}}, push} + {{AW{1'b0}}, pop};
  assign af_d       = (free_after <= AF_FREE_W);
  assign ovfl_d     = ovfl_q | (s1_valid_q & ~push);

  lamp_fpu_sqrt_res_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (push),
    .wr_data_i (entry_d),
    .rd_en_i   (pop),
    .rd_data_o (head_w),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .free_o    (fifo_free)
  );

  // Status registers: occupancy warning after this edge, sticky drop flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      af_q   <= 1'b0;
      ovfl_q <= 1'b0;
    end else begin
      af_q   <= af_d;
      ovfl_q <= ovfl_d;
    end
  end

  assign head          = head_w;
  assign result_o      = {head.s, head.e, head.f};
  assign valid_o       = ~fifo_empty;
  assign almost_full_o = af_q;
  assign ovfl_o        = ovfl_q;
`ifdef LAMP_SQRT_PACK_FLAGS_EN
  assign flagNX_o      = head.nx;
  assign flagOF_o      = head.of;
  assign flagNV_o      = head.nv;
`endif

endmodule

// File: doc/lamp_fpu_sqrt_pack.md
# lamp_fpu_sqrt_pack

Round-and-pack back end for the square-root unit. It consumes the unpacked `{sign, exponent, extended significand}` result stream and applies round-to-nearest-even when requested. It then packs a 16-bit bfloat16 word and buffers results in a small FIFO drained through a valid/ready handshake. It sits between the square-root datapath and the FPU result bus or register-file write port.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries; a power of two, at least 2.
- `AF_FREE`, default 1: `almost_full_o` asserts when free entries are at most this value.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `valid_i`  in  1  result present on the inputs this cycle; cannot be stalled.
- `s_res_i`  in  1  result sign.
- `e_res_i`  in  8  biased exponent.
- `f_res_i`  in  12  bit[11] carry (0 on entry), bit[10] hidden bit, bits[9:3] fraction, bit[2] guard, bit[1] round, bit[0] sticky.
- `isToRound_i`  in  1  1: round the value; 0: special value (zero/Inf/NaN), pass it through unrounded.
- `result_o`  out  16  packed `{s, e[7:0], frac[6:0]}`.
- `valid_o`  out  1  FIFO head valid.
- `ready_i`  in  1  consumer accepts the head.
- `almost_full_o`  out  1  issuer must withhold new square-root requests.
- `ovfl_o`  out  1  sticky: a result was dropped.
- `flagNX_o`, `flagOF_o`, `flagNV_o`  out  1 each  per-entry flags; present only under the macro in Configuration.

## Operation
- Stage 1 is a registered capture of the inputs when `valid_i` is high (`s1_valid` <= `valid_i`).
- Stage 2 performs rounding on the stage-1 register, combinationally, then writes the FIFO.
- Rounding applies when `isToRound`=1:
  - `lsb`=f[3], `G`=f[2], `R`=f[1], `S`=f[0].
  - `up` = G & (R | S | lsb).
  - `m[8:0]` = {1'b0, f[10:3]} + `up`.
  - If `m[8]`=1: frac = `m[7:1]` and e = e+1.
  - Otherwise: frac = `m[6:0]` and e unchanged.
  - If the resulting e equals 8'hFF, the output is Inf: frac forced to 0 and OF set.
  - NX = G|R|S.
- Pass-through applies when `isToRound`=0: output is {s, e, f[9:3]} verbatim, with NX=OF=0. NV=1 when e=8'hFF and frac≠0.
- FIFO:
  - Write when `s1_valid` and (not full, or pop in the same cycle).
  - Pop when `valid_o & ready_i`.
  - Simultaneous push and pop: occupancy unchanged, both actions take effect, including when full.
  - Write while full without a pop: the entry is dropped and `ovfl_o` sets. `ovfl_o` clears only on reset.
  - Pointers are `$clog2(DEPTH)` bits wide with an extra wrap bit; full/empty is decided by wrap-bit compare.
  - `result_o` is the registered head entry and is held stable while `valid_o & ~ready_i`.
- There is no state machine beyond the FIFO occupancy: empty -> partial -> full, and back.

## Timing
- Latency is 2 cycles. With `valid_i` high at edge E0, stage 1 loads at E0, the FIFO write happens at E1, and `valid_o`=1 after E1 if the FIFO was empty.
- Throughput is one result per cycle when `ready_i` is held high.
- Reset values:
  - All outputs are 0.
  - `valid_o`=0, `almost_full_o`=0, `ovfl_o`=0, `result_o`=16'h0000.
  - Pointers and `s1_valid` are 0.
- Reset asserted mid-operation discards stage 1 and all FIFO contents immediately, without waiting for a clock edge.
- `almost_full_o` is registered and tracks occupancy after the current edge's push and pop.

## Configuration
- `LAMP_SQRT_PACK_FLAGS_EN` defined:
  - NX, OF and NV are computed and stored as 3 extra bits per FIFO entry.
  - They are output on `flagNX_o`, `flagOF_o` and `flagNV_o`, aligned with `result_o`.
- Undefined: the flag ports are absent, the FIFO is 16 bits wide, and the flag logic is not synthesized.

## Structure
- `lampFPU_pkg` holds:
  - `LAMP_FLOAT_DW`=16, `LAMP_FLOAT_E_DW`, `LAMP_FLOAT_F_DW`, and the existing `INF_E_F`/`QNAN_E_F` constants.
  - A new function `FUNC_rndNearestEvenSqrt` returning {e, frac, NX, OF}.
  - A new typedef `lampSqrtPackEntry_t` for the FIFO word.
- One sub-module, `lamp_fpu_sqrt_res_fifo`: a parameterized width/depth synchronous FIFO with async reset, full/empty, and a free-count output.

## Test plan
- Tie stays even: isToRound=1, s=0, e=8'h7F, f=12'h404 -> result 16'h3F80, NX=1, OF=0, latency 2.
- Tie rounds up: f=12'h40C, e=8'h7F -> result 16'h3F82, NX=1.
- Carry out: e=8'h7F, f=12'h5FE -> result 16'h4000. Same f with e=8'hFE -> result 16'h7F80, OF=1.
- Pass-through NaN: isToRound=0, s=0, e=8'hFF, f=12'h600 -> result 16'h7FC0, NV=1, NX=0. Pass-through zero: e=0, f=0 -> 16'h0000.
- Backpressure (DEPTH=4, ready_i=0), 5 back-to-back inputs:
  - `almost_full_o` rises after the 3rd write.
  - The 5th input is dropped and `ovfl_o`=1.
  - Then raise `ready_i`: exactly 4 results drain, in order.
  - Push+pop while full: no drop.
- Reset mid-stream: assert `rst` between edges with 2 entries queued -> `valid_o` and `almost_full_o` go to 0 at once, and `ovfl_o` goes to 0. After release, the next input appears 2 cycles later.
